// File: rtl/serial_pkg.sv
// Shared definitions for the serial link: FSM encoding, line levels and frame sizing.
package serial_pkg;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_START  = 3'd1,
      ST_DATA   = 3'd2,
      ST_PARITY = 3'd3,
      ST_STOP   = 3'd4
   } tx_state_e;

   localparam logic LINE_IDLE = 1'b1;
   localparam logic START_LVL = 1'b0;

   // Cycles from handshake to the first idle cycle of the following gap.
   function automatic int unsigned frame_cycles(input int unsigned data_w,
                                                input int unsigned clks_per_bit,
                                                input bit          parity_en);
      int unsigned nbits;
      nbits = 32'd2 + data_w + (parity_en ? 32'd1 : 32'd0);
      return nbits * clks_per_bit;
   endfunction

endpackage

// File: rtl/serial_tx_bit_timer.sv
// Baud counter: tick marks the last clk cycle of each bit period; clear holds it at zero.
module bit_timer #(
   parameter int unsigned CLKS_PER_BIT = 4
) (
   input  logic clk,
   input  logic rst,
   input  logic clear,
   output logic tick
);

   localparam int unsigned CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

   logic [CW-1:0] cnt_q;
   logic [CW-1:0] cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (clear || (cnt_q == LAST)) begin
         cnt_d = '0;
      end else begin
         cnt_d = cnt_q + CW'(1);
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign tick = !clear && (cnt_q == LAST);

endmodule

// File: rtl/serial_tx.sv
// Serial transmitter: valid/ready word in, start + LSB-first data + optional even parity + stop out.
module serial_tx
   import serial_pkg::*;
#(
   parameter int unsigned DATA_W       = 8,
   parameter int unsigned CLKS_PER_BIT = 4,
   parameter bit          PARITY_EN    = 1'b0
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              tx_valid,
   input  logic [DATA_W-1:0] tx_data,
   output logic              tx_ready,
   output logic              txd,
   output logic              busy
);

   localparam int unsigned BW = $clog2(DATA_W) + 1;
   localparam logic [BW-1:0] LAST_BIT = BW'(DATA_W - 1);

   tx_state_e         state_q, state_d;
   logic [DATA_W-1:0] shift_q, shift_d;
   logic [BW-1:0]     bit_cnt_q, bit_cnt_d;
   logic              parity_q, parity_d;
   logic              txd_q, txd_d;
   logic              busy_q, busy_d;
   logic              ready_q, ready_d;
   logic              tick;
   logic              timer_clear;
   logic              handshake;

   assign timer_clear = (state_q == ST_IDLE);
   assign handshake   = tx_valid && ready_q;

   bit_timer #(
      .CLKS_PER_BIT(CLKS_PER_BIT)
   ) u_bit_timer (
      .clk  (clk),
      .rst  (rst),
      .clear(timer_clear),
      .tick (tick)
   );

   // Outputs are computed one cycle ahead so txd/busy/tx_ready come straight from flops.
   always_comb begin
      state_d   = state_q;
      shift_d   = shift_q;
      bit_cnt_d = bit_cnt_q;
      parity_d  = parity_q;
      txd_d     = txd_q;
      busy_d    = busy_q;
      ready_d   = ready_q;

      unique case (state_q)
         ST_IDLE: begin
            if (handshake) begin
               shift_d   = tx_data;
               parity_d  = ^tx_data;
               bit_cnt_d = '0;
               state_d   = ST_START;
               txd_d     = START_LVL;
               busy_d    = 1'b1;
               ready_d   = 1'b0;
            end
         end
         ST_START: begin
            if (tick) begin
               state_d = ST_DATA;
               txd_d   = shift_q[0];
            end
         end
         ST_DATA: begin
            if (tick) begin
               shift_d = shift_q >> 1;
               if (bit_cnt_q == LAST_BIT) begin
                  bit_cnt_d = '0;
                  if (PARITY_EN) begin
                     state_d = ST_PARITY;
                     txd_d   = parity_q;
                  end else begin
                     state_d = ST_STOP;
                     txd_d   = LINE_IDLE;
                  end
               end else begin
                  bit_cnt_d = bit_cnt_q + BW'(1);
                  txd_d     = shift_d[0];
               end
            end
         end
         ST_PARITY: begin
            if (tick) begin
               state_d = ST_STOP;
               txd_d   = LINE_IDLE;
            end
         end
         ST_STOP: begin
            if (tick) begin
               state_d = ST_IDLE;
               txd_d   = LINE_IDLE;
               busy_d  = 1'b0;
               ready_d = 1'b1;
            end
         end
         default: begin
            state_d   = ST_IDLE;
            bit_cnt_d = '0;
            txd_d     = LINE_IDLE;
            busy_d    = 1'b0;
            ready_d   = 1'b1;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q   <= ST_IDLE;
         shift_q   <= '0;
         bit_cnt_q <= '0;
         parity_q  <= 1'b0;
         txd_q     <= LINE_IDLE;
         busy_q    <= 1'b0;
         ready_q   <= 1'b1;
      end else begin
         state_q   <= state_d;
         shift_q   <= shift_d;
         bit_cnt_q <= bit_cnt_d;
         parity_q  <= parity_d;
         txd_q     <= txd_d;
         busy_q    <= busy_d;
         ready_q   <= ready_d;
      end
   end

   assign txd      = txd_q;
   assign busy     = busy_q;
   assign tx_ready = ready_q;

endmodule

// File: tb/tb_serial_tx.sv
// Directed bench for serial_tx: three configurations checked cycle by cycle against hand-built frames.
module tb_serial_tx;

   logic       clk = 1'b0;
   logic       rst;
   logic [2:0] valid;
   logic [7:0] data [3];
   logic [2:0] txd_w;
   logic [2:0] rdy_w;
   logic [2:0] busy_w;

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   serial_tx #(.DATA_W(8), .CLKS_PER_BIT(4), .PARITY_EN(1'b0)) u_dut_np (
      .clk(clk), .rst(rst), .tx_valid(valid[0]), .tx_data(data[0]),
      .tx_ready(rdy_w[0]), .txd(txd_w[0]), .busy(busy_w[0]));

   serial_tx #(.DATA_W(8), .CLKS_PER_BIT(4), .PARITY_EN(1'b1)) u_dut_p (
      .clk(clk), .rst(rst), .tx_valid(valid[1]), .tx_data(data[1]),
      .tx_ready(rdy_w[1]), .txd(txd_w[1]), .busy(busy_w[1]));

   serial_tx #(.DATA_W(8), .CLKS_PER_BIT(1), .PARITY_EN(1'b0)) u_dut_c1 (
      .clk(clk), .rst(rst), .tx_valid(valid[2]), .tx_data(data[2]),
      .tx_ready(rdy_w[2]), .txd(txd_w[2]), .busy(busy_w[2]));

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Expected line level for bit slot idx of a frame carrying w.
   function automatic logic frame_bit(input logic [7:0] w, input int idx, input bit par);
      if (idx == 0) return 1'b0;
      if (idx <= 8) return w[idx-1];
      if (par && idx == 9) return ^w;
      return 1'b1;
   endfunction

   task automatic send_frame(input int d, input logic [7:0] w, input int cpb, input bit par,
                             input int pulse_at, input string tag);
      int ncyc;
      ncyc = (10 + (par ? 1 : 0)) * cpb;
      @(negedge clk);
      check({tag, " ready_before"}, 32'(rdy_w[d]), 1);
      data[d]  = w;
      valid[d] = 1'b1;
      @(posedge clk); #1;
      valid[d] = 1'b0;
      data[d]  = ~w;
      for (int i = 0; i < ncyc; i++) begin
         if (i > 0) begin
            @(posedge clk); #1;
         end
         valid[d] = (i == pulse_at);
         if (i == pulse_at) data[d] = 8'hFF;
         check($sformatf("%s txd c%0d", tag, i + 1), 32'(txd_w[d]), 32'(frame_bit(w, i / cpb, par)));
         check($sformatf("%s busy_rdy c%0d", tag, i + 1), 32'({busy_w[d], rdy_w[d]}), 2);
      end
      @(posedge clk); #1;
      valid[d] = 1'b0;
      check({tag, " end_rdy_busy_txd"}, 32'({rdy_w[d], busy_w[d], txd_w[d]}), 5);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int   toggles;
      logic [2:0] prev;

      valid = '0;
      for (int d = 0; d < 3; d++) data[d] = 8'h00;
      rst = 1'b0;

      // 1. reset values and quiet idle line
      #10;
      check("in_reset txd", 32'(txd_w), 7);
      check("in_reset rdy", 32'(rdy_w), 7);
      check("in_reset busy", 32'(busy_w), 0);
      #10;
      rst = 1'b1;
      @(posedge clk); #1;
      check("post_reset txd", 32'(txd_w), 7);
      check("post_reset rdy", 32'(rdy_w), 7);
      check("post_reset busy", 32'(busy_w), 0);
      toggles = 0;
      prev = txd_w;
      for (int i = 0; i < 50; i++) begin
         @(posedge clk); #1;
         if (txd_w != prev) toggles++;
         prev = txd_w;
      end
      check("idle_toggles", 32'(toggles), 0);
      check("frame_cycles 8/4/1", serial_pkg::frame_cycles(8, 4, 1'b1), 44);
      check("frame_cycles 8/4/0", serial_pkg::frame_cycles(8, 4, 1'b0), 40);

      // 2. no parity, 4 clocks per bit
      send_frame(0, 8'hA5, 4, 1'b0, -1, "np_A5");

      // 3. even parity: 0x07 -> parity 1, 0xA5 -> parity 0
      send_frame(1, 8'h07, 4, 1'b1, -1, "p_07");
      send_frame(1, 8'hA5, 4, 1'b1, -1, "p_A5");

      // 4. back-to-back frames with tx_valid held, 1 clock per bit
      @(negedge clk);
      data[2]  = 8'h3C;
      valid[2] = 1'b1;
      @(posedge clk); #1;
      for (int i = 1; i <= 21; i++) begin
         logic e;
         if (i > 1) begin
            @(posedge clk); #1;
         end
         if (i == 3)  data[2]  = 8'hFF;
         if (i == 7)  data[2]  = 8'hC3;
         if (i == 12) valid[2] = 1'b0;
         if (i <= 10)      e = frame_bit(8'h3C, i - 1, 1'b0);
         else if (i == 11) e = 1'b1;
         else              e = frame_bit(8'hC3, i - 12, 1'b0);
         check($sformatf("b2b txd c%0d", i), 32'(txd_w[2]), 32'(e));
         check($sformatf("b2b busy c%0d", i), 32'(busy_w[2]), (i == 11) ? 0 : 1);
         if (i == 11) check("b2b gap_ready", 32'(rdy_w[2]), 1);
      end
      @(posedge clk); #1;
      check("b2b end_rdy", 32'(rdy_w[2]), 1);
      @(posedge clk); #1;
      check("b2b no_third", 32'({busy_w[2], txd_w[2]}), 1);

      // 5. asynchronous reset during data bit 3 (0xA5 bit 3 is 0)
      @(negedge clk);
      data[0]  = 8'hA5;
      valid[0] = 1'b1;
      @(posedge clk); #1;
      valid[0] = 1'b0;
      repeat (17) @(posedge clk);
      #1;
      check("abort pre_txd", 32'(txd_w[0]), 0);
      check("abort pre_busy", 32'(busy_w[0]), 1);
      #2;
      rst = 1'b0;
      #1;
      check("abort txd", 32'(txd_w[0]), 1);
      check("abort busy", 32'(busy_w[0]), 0);
      check("abort rdy", 32'(rdy_w[0]), 1);
      @(negedge clk);
      @(negedge clk);
      rst = 1'b1;
      send_frame(0, 8'h5A, 4, 1'b0, -1, "np_5A_after_rst");

      // 6. tx_valid pulse while busy is ignored
      send_frame(1, 8'h07, 4, 1'b1, 12, "p_07_pulse");
      for (int i = 0; i < 5; i++) begin
         @(posedge clk); #1;
         check($sformatf("pulse no_frame c%0d", i), 32'({busy_w[1], rdy_w[1], txd_w[1]}), 3);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
